// File: rtl/encryption_mac_engine.sv
// encryption_mac_engine
//   Transmit-side word cipher with a running message MAC. Each accepted
//   plaintext word goes through ROUNDS iterations of an invertible round
//   function (one round per clock), using round keys derived from the key
//   latched at accept. Each ciphertext word handed downstream is folded into
//   a MAC register. When the word marked `last` is handed off, the MAC is
//   published on e_MAC and the register restarts for the next message.
//
//   Build option: define ENC_MAC_EN to compile in the MAC register and the
//   `last` handling. If it is undefined, e_MAC and mac_valid are tied to 0,
//   `last` is ignored, and the ciphertext path keeps the same timing.
//
// Ports
//   clock, reset_n        rising-edge clock, async active-low reset
//   in_valid / in_ready   plaintext handshake (key, data, last sampled at accept)
//   key, data  [N-1:0]    key and plaintext word
//   last                  marks the final word of a message
//   out_valid / out_ready ciphertext handshake
//   e_data     [N-1:0]    ciphertext, held while stalled
//   e_MAC      [N-1:0]    MAC of the most recently completed message
//   mac_valid             one-cycle pulse when e_MAC is updated
module encryption_mac_engine #(
   parameter int N      = 8,
   parameter int ROUNDS = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] key,
   input  logic [N-1:0] data,
   input  logic         last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] e_data,
   output logic [N-1:0] e_MAC,
   output logic         mac_valid
);
   localparam int RW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

   state_t        state;
   logic [N-1:0]  key_q;
   logic [N-1:0]  x_q;
   logic [N-1:0]  rcnt;      // round index r
   logic [RW-1:0] rot_q;     // r mod N, tracked alongside rcnt to avoid a divider
   logic [N-1:0]  rk;
   logic [N-1:0]  x_nxt;
   logic          accept;
   logic          out_hs;

   function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input logic [RW-1:0] s);
      logic [2*N-1:0] d;
      d = {v, v} << s;
      return d[2*N-1:N];
   endfunction

   function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
      return {v[N-2:0], v[N-1]};
   endfunction

   assign accept = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

   assign rk    = rotl(key_q, rot_q) ^ rcnt;
   assign x_nxt = rotl1(x_q ^ rk) + rk;

   // in_ready and out_valid are registered copies of (state==IDLE) and
   // (state==OUT). They are updated on the same edges as the state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         e_data    <= '0;
         key_q     <= '0;
         x_q       <= '0;
         rcnt      <= '0;
         rot_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  key_q    <= key;
                  x_q      <= data;
                  rcnt     <= '0;
                  rot_q    <= '0;
                  in_ready <= 1'b0;
                  state    <= ROUND;
               end
            end
            ROUND: begin
               x_q   <= x_nxt;
               rcnt  <= rcnt + N'(1);
               rot_q <= (rot_q == RW'(N - 1)) ? '0 : rot_q + RW'(1);
               if (rcnt == N'(ROUNDS - 1)) begin
                  e_data    <= x_nxt;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_hs) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef ENC_MAC_EN
   logic         last_q;
   logic [N-1:0] mac_q;
   logic [N-1:0] mac_nxt;

   // Each word is folded in as it leaves. e_data is stable during OUT, so the
   // value used here is exactly the word being handed off.
   assign mac_nxt = rotl1(mac_q ^ e_data);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_q    <= 1'b0;
         mac_q     <= '0;
         e_MAC     <= '0;
         mac_valid <= 1'b0;
      end else begin
         mac_valid <= 1'b0;
         if (accept) last_q <= last;
         if (out_hs) begin
            if (last_q) begin
               e_MAC     <= mac_nxt;
               mac_valid <= 1'b1;
               mac_q     <= '0;
            end else begin
               mac_q <= mac_nxt;
            end
         end
      end
   end
`else
   logic unused_last;
   assign unused_last = last;
   assign e_MAC       = '0;
   assign mac_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_encryption_mac_engine.sv
module tb_encryption_mac_engine;
   localparam int N      = 8;
   localparam int ROUNDS = 4;
   localparam int MASK   = (1 << N) - 1;
`ifdef ENC_MAC_EN
   localparam bit MAC_EN = 1'b1;
`else
   localparam bit MAC_EN = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] key = '0;
   logic [N-1:0] data = '0;
   logic         last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] e_data;
   logic [N-1:0] e_MAC;
   logic         mac_valid;

   int n_checks = 0;
   int n_fail = 0;
   int pulse_cnt = 0;
   int cyc = 0;
   int acc_q[$];

   // reference model state: running MAC and last published MAC
   logic [N-1:0] mac_m = '0;
   logic [N-1:0] emac_m = '0;

   always #5 clock = ~clock;

   encryption_mac_engine #(.N(N), .ROUNDS(ROUNDS)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .key(key), .data(data), .last(last),
      .out_valid(out_valid), .out_ready(out_ready),
      .e_data(e_data), .e_MAC(e_MAC), .mac_valid(mac_valid)
   );

   always @(negedge clock) if (mac_valid) pulse_cnt++;
   always @(posedge clock) begin
      cyc++;
      if (reset_n && in_valid && in_ready) acc_q.push_back(cyc);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Cipher computed directly from the round equations, using integer arithmetic.
   function automatic logic [N-1:0] model_enc(input logic [N-1:0] k, input logic [N-1:0] d);
      int kk, x, rk, s, t;
      kk = int'(k);
      x  = int'(d);
      for (int r = 0; r < ROUNDS; r++) begin
         s  = r % N;
         rk = (((kk << s) | (kk >> (N - s))) & MASK) ^ (r & MASK);
         t  = x ^ rk;
         x  = ((((t << 1) | (t >> (N - 1))) & MASK) + rk) & MASK;
      end
      return N'(x);
   endfunction

   task automatic model_word(input logic [N-1:0] c, input logic l,
                             output logic exp_mv, output logic [N-1:0] exp_em);
      int t;
      exp_mv = 1'b0;
      if (MAC_EN) begin
         t = int'(mac_m ^ c);
         mac_m = N'(((t << 1) | (t >> (N - 1))) & MASK);
         if (l) begin
            emac_m = mac_m;
            mac_m  = '0;
            exp_mv = 1'b1;
         end
      end
      exp_em = emac_m;
   endtask

   // Sends one word and collects what the DUT produced. If stall > 0, out_ready
   // is held low that many cycles while OUT, and in_valid is driven high to
   // check that it is ignored.
   task automatic xfer(input logic [N-1:0] k, input logic [N-1:0] d, input logic l, input int stall,
                       output logic [N-1:0] ed, output int lat, output logic mv,
                       output logic [N-1:0] em, output logic ir, output int bad, output logic to);
      int n;
      to = 1'b0; bad = 0; lat = 0; ed = '0; mv = 1'b0; em = '0; ir = 1'b0;
      out_ready = (stall == 0);
      @(negedge clock);
      key = k; data = d; last = l; in_valid = 1'b1;
      n = 0;
      while (!in_ready) begin
         @(negedge clock);
         n++;
         if (n > 50) begin to = 1'b1; in_valid = 1'b0; return; end
      end
      @(posedge clock); #1;
      in_valid = 1'b0; key = N'($urandom); data = N'($urandom); last = 1'($urandom);
      while (!out_valid) begin
         @(posedge clock); #1;
         lat++;
         if (lat > 50) begin to = 1'b1; return; end
      end
      ed = e_data;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         @(posedge clock); #1;
         if (!out_valid || e_data !== ed || in_ready) bad++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      mv = mac_valid; em = e_MAC; ir = in_ready;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      n_checks++; if (e_data !== '0) begin n_fail++; $display("FAIL reset_e_data: got %0h expected 0", e_data); end
      n_checks++; if (e_MAC !== '0) begin n_fail++; $display("FAIL reset_e_MAC: got %0h expected 0", e_MAC); end
      n_checks++; if (mac_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mac_valid: got %0b expected 0", mac_valid); end
   endtask

   task automatic test_single;
      logic [N-1:0] ed, em, xem; logic mv, ir, to, xmv; int lat, bad;
      xfer(8'h00, 8'h00, 1'b1, 0, ed, lat, mv, em, ir, bad, to);
      model_word(model_enc(8'h00, 8'h00), 1'b1, xmv, xem);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %0b expected 0", to); end
      n_checks++; if (lat != ROUNDS) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, ROUNDS); end
      n_checks++; if (ed !== 8'h11) begin n_fail++; $display("FAIL single_e_data: got %0h expected 11", ed); end
      n_checks++; if (mv !== xmv) begin n_fail++; $display("FAIL single_mac_valid: got %0b expected %0b", mv, xmv); end
      n_checks++; if (em !== (MAC_EN ? 8'h22 : 8'h00)) begin n_fail++; $display("FAIL single_e_MAC: got %0h expected %0h", em, (MAC_EN ? 8'h22 : 8'h00)); end
      n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL single_in_ready_after_hs: got %0b expected 1", ir); end
      @(posedge clock); #1;
      n_checks++; if (mac_valid !== 1'b0) begin n_fail++; $display("FAIL single_mac_pulse_width: got %0b expected 0", mac_valid); end
   endtask

   task automatic test_key_ff;
      logic [N-1:0] ed, em, xem; logic mv, ir, to, xmv; int lat, bad;
      xfer(8'hFF, 8'h00, 1'b1, 0, ed, lat, mv, em, ir, bad, to);
      model_word(model_enc(8'hFF, 8'h00), 1'b1, xmv, xem);
      n_checks++; if (ed !== 8'hFB) begin n_fail++; $display("FAIL keyff_e_data: got %0h expected fb", ed); end
      n_checks++; if (em !== xem) begin n_fail++; $display("FAIL keyff_e_MAC: got %0h expected %0h", em, xem); end
   endtask

   task automatic test_two_word;
      logic [N-1:0] ed, em, xem; logic mv, ir, to, xmv; int lat, bad, p0;
      p0 = pulse_cnt;
      xfer(8'h00, 8'h00, 1'b0, 0, ed, lat, mv, em, ir, bad, to);
      model_word(model_enc(8'h00, 8'h00), 1'b0, xmv, xem);
      n_checks++; if (ed !== 8'h11) begin n_fail++; $display("FAIL two_word_first_e_data: got %0h expected 11", ed); end
      n_checks++; if (mv !== 1'b0) begin n_fail++; $display("FAIL two_word_first_mac_valid: got %0b expected 0", mv); end
      xfer(8'hFF, 8'h00, 1'b1, 0, ed, lat, mv, em, ir, bad, to);
      model_word(model_enc(8'hFF, 8'h00), 1'b1, xmv, xem);
      n_checks++; if (ed !== 8'hFB) begin n_fail++; $display("FAIL two_word_second_e_data: got %0h expected fb", ed); end
      n_checks++; if (mv !== xmv) begin n_fail++; $display("FAIL two_word_mac_valid: got %0b expected %0b", mv, xmv); end
      n_checks++; if (em !== (MAC_EN ? 8'hB3 : 8'h00)) begin n_fail++; $display("FAIL two_word_e_MAC: got %0h expected %0h", em, (MAC_EN ? 8'hB3 : 8'h00)); end
      @(negedge clock);
      n_checks++; if (pulse_cnt - p0 != (MAC_EN ? 1 : 0)) begin n_fail++; $display("FAIL two_word_pulse_count: got %0d expected %0d", pulse_cnt - p0, (MAC_EN ? 1 : 0)); end
   endtask

   task automatic test_backpressure;
      logic [N-1:0] k, d, ed, em, xem; logic mv, ir, to, xmv; int lat, bad;
      k = N'($urandom); d = N'($urandom);
      xfer(k, d, 1'b1, 10, ed, lat, mv, em, ir, bad, to);
      model_word(model_enc(k, d), 1'b1, xmv, xem);
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL backpressure_stall_cycles: got %0d bad cycles expected 0", bad); end
      n_checks++; if (ed !== model_enc(k, d)) begin n_fail++; $display("FAIL backpressure_e_data: got %0h expected %0h", ed, model_enc(k, d)); end
      n_checks++; if (mv !== xmv || em !== xem) begin n_fail++; $display("FAIL backpressure_mac: got %0b/%0h expected %0b/%0h", mv, em, xmv, xem); end
      n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL backpressure_in_ready: got %0b expected 1", ir); end
   endtask

   task automatic test_reset_mid_round;
      logic [N-1:0] ed, em, xem; logic mv, ir, to, xmv; int lat, bad, p0;
      xfer(8'h5A, 8'h3C, 1'b0, 0, ed, lat, mv, em, ir, bad, to);
      model_word(model_enc(8'h5A, 8'h3C), 1'b0, xmv, xem);
      @(negedge clock);
      key = 8'h00; data = 8'h00; last = 1'b1; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      p0 = pulse_cnt;
      reset_n = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %0b expected 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %0b expected 0", out_valid); end
      n_checks++; if (e_data !== '0) begin n_fail++; $display("FAIL midreset_e_data: got %0h expected 0", e_data); end
      n_checks++; if (e_MAC !== '0) begin n_fail++; $display("FAIL midreset_e_MAC: got %0h expected 0", e_MAC); end
      n_checks++; if (mac_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_mac_valid: got %0b expected 0", mac_valid); end
      mac_m = '0; emac_m = '0;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL midreset_no_pulse: got %0d expected %0d", pulse_cnt, p0); end
      xfer(8'h00, 8'h00, 1'b1, 0, ed, lat, mv, em, ir, bad, to);
      model_word(model_enc(8'h00, 8'h00), 1'b1, xmv, xem);
      n_checks++; if (ed !== 8'h11) begin n_fail++; $display("FAIL midreset_after_e_data: got %0h expected 11", ed); end
      n_checks++; if (em !== (MAC_EN ? 8'h22 : 8'h00)) begin n_fail++; $display("FAIL midreset_after_e_MAC: got %0h expected %0h", em, (MAC_EN ? 8'h22 : 8'h00)); end
   endtask

   task automatic test_back_to_back;
      logic [N-1:0] ed, em, xem; logic mv, ir, to, xmv; int lat, bad, gap;
      xfer(8'h12, 8'h34, 1'b0, 0, ed, lat, mv, em, ir, bad, to);
      model_word(model_enc(8'h12, 8'h34), 1'b0, xmv, xem);
      xfer(8'hA5, 8'hC3, 1'b1, 0, ed, lat, mv, em, ir, bad, to);
      model_word(model_enc(8'hA5, 8'hC3), 1'b1, xmv, xem);
      gap = (acc_q.size() >= 2) ? acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2] : -1;
      n_checks++; if (gap != ROUNDS + 2) begin n_fail++; $display("FAIL back_to_back_gap: got %0d expected %0d", gap, ROUNDS + 2); end
      n_checks++; if (ed !== model_enc(8'hA5, 8'hC3) || em !== xem) begin n_fail++; $display("FAIL back_to_back_data: got %0h/%0h expected %0h/%0h", ed, em, model_enc(8'hA5, 8'hC3), xem); end
   endtask

   task automatic test_random;
      logic [N-1:0] k, d, ed, em, xem; logic l, mv, ir, to, xmv; int lat, bad, p0, xp;
      p0 = pulse_cnt; xp = 0;
      for (int i = 0; i < 30; i++) begin
         k = N'($urandom); d = N'($urandom);
         l = (i == 29) ? 1'b1 : ($urandom_range(0, 3) == 0);
         xfer(k, d, l, $urandom_range(0, 2), ed, lat, mv, em, ir, bad, to);
         model_word(model_enc(k, d), l, xmv, xem);
         if (xmv) xp++;
         n_checks++; if (to !== 1'b0 || lat != ROUNDS || bad != 0) begin n_fail++; $display("FAIL random_timing[%0d]: got to=%0b lat=%0d bad=%0d expected 0/%0d/0", i, to, lat, bad, ROUNDS); end
         n_checks++; if (ed !== model_enc(k, d)) begin n_fail++; $display("FAIL random_e_data[%0d]: got %0h expected %0h", i, ed, model_enc(k, d)); end
         n_checks++; if (mv !== xmv || em !== xem) begin n_fail++; $display("FAIL random_mac[%0d]: got %0b/%0h expected %0b/%0h", i, mv, em, xmv, xem); end
      end
      @(negedge clock);
      n_checks++; if (pulse_cnt - p0 != xp) begin n_fail++; $display("FAIL random_pulse_count: got %0d expected %0d", pulse_cnt - p0, xp); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_key_ff();
      test_two_word();
      test_backpressure();
      test_reset_mid_round();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
